// File: rtl/ps2_rx_decoder_if.sv
// Receive-side bus of the PS/2 decoder: raw bytes, frame errors and collapsed key events.
interface ps2_rx_decoder_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic [7:0] key_code;
  logic       key_break;
  logic       key_ext;
  logic       key_valid;

  modport master (
    output rx_data, rx_valid, rx_err,
    output key_code, key_break, key_ext, key_valid
  );

  modport slave (
    input rx_data, rx_valid, rx_err,
    input key_code, key_break, key_ext, key_valid
  );
endinterface

// File: rtl/ps2_rx_decoder.sv
// PS/2 keyboard receiver: pin synchronisation, clock deglitch, 11-bit frame
// deserialisation with start/parity/stop checks, frame watchdog, and E0/F0
// prefix collapsing into single key events.
module ps2_rx_decoder #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 100000,
  parameter int TO_WIDTH   = 17
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  ps2_rx_decoder_if.master bus
);

  localparam int FW = $clog2(FILTER_LEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // Synchronisers and clock filter
  logic          clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
  logic          filt_clk_q, filt_clk_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          fall_tick;

  // Frame receiver
  state_t              state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic                parity_q, parity_d;
  logic [TO_WIDTH-1:0] wd_q, wd_d;
  logic [7:0]          rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                rx_err_q, rx_err_d;

  // Key event decoder
  logic [7:0] key_code_q, key_code_d;
  logic       key_break_q, key_break_d;
  logic       key_ext_q, key_ext_d;
  logic       key_valid_q, key_valid_d;
  logic       ext_pend_q, ext_pend_d;
  logic       brk_pend_q, brk_pend_d;

  // Two-flop synchronisers for both asynchronous pins (idle-high reset value)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      data_s1_q <= 1'b1;
      data_s2_q <= 1'b1;
    end else begin
      clk_s1_q  <= ps2_clk;
      clk_s2_q  <= clk_s1_q;
      data_s1_q <= ps2_data;
      data_s2_q <= data_s1_q;
    end
  end

  // Filtered clock flips only after FILTER_LEN consecutive disagreeing samples
  always_comb begin
    filt_clk_d = filt_clk_q;
    filt_cnt_d = filt_cnt_q;
    if (clk_s2_q == filt_clk_q) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
      filt_clk_d = ~filt_clk_q;
      filt_cnt_d = '0;
    end else begin
      filt_cnt_d = filt_cnt_q + FW'(1);
    end
    fall_tick = filt_clk_q & ~filt_clk_d;
  end

  // Filter state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_clk_q <= 1'b1;
      filt_cnt_q <= '0;
    end else begin
      filt_clk_q <= filt_clk_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  // Frame FSM next state: advances on fall ticks, watchdog aborts stalled frames
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    if (state_q == S_IDLE || fall_tick) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + TO_WIDTH'(1);
    end

    if (fall_tick) begin
      case (state_q)
        S_IDLE: begin
          if (!data_s2_q) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end
        end
        S_DATA: begin
          shift_d   = {data_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_PARITY;
          end
        end
        S_PARITY: begin
          parity_d = data_s2_q;
          state_d  = S_STOP;
        end
        S_STOP: begin
          if (data_s2_q && (^{shift_q, parity_q})) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            rx_err_d = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && wd_q == TO_WIDTH'(TIMEOUT - 1)) begin
      state_d  = S_IDLE;
      rx_err_d = 1'b1;
      wd_d     = '0;
    end
  end

  // Frame FSM state and receive outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      wd_q       <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      wd_q       <= wd_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
    end
  end

  // Prefix collapsing: E0/F0 arm pending flags, any other byte emits a key event
  always_comb begin
    key_code_d  = key_code_q;
    key_break_d = key_break_q;
    key_ext_d   = key_ext_q;
    key_valid_d = 1'b0;
    ext_pend_d  = ext_pend_q;
    brk_pend_d  = brk_pend_q;
    if (rx_err_q) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end else if (rx_valid_q) begin
      case (rx_data_q)
        8'hE0:   ext_pend_d = 1'b1;
        8'hF0:   brk_pend_d = 1'b1;
        default: begin
          key_code_d  = rx_data_q;
          key_break_d = brk_pend_q;
          key_ext_d   = ext_pend_q;
          key_valid_d = 1'b1;
          ext_pend_d  = 1'b0;
          brk_pend_d  = 1'b0;
        end
      endcase
    end
  end

  // Key event registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_code_q  <= '0;
      key_break_q <= 1'b0;
      key_ext_q   <= 1'b0;
      key_valid_q <= 1'b0;
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
    end else begin
      key_code_q  <= key_code_d;
      key_break_q <= key_break_d;
      key_ext_q   <= key_ext_d;
      key_valid_q <= key_valid_d;
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.rx_err    = rx_err_q;
  assign bus.key_code  = key_code_q;
  assign bus.key_break = key_break_q;
  assign bus.key_ext   = key_ext_q;
  assign bus.key_valid = key_valid_q;

endmodule

// File: tb/tb_ps2_rx_decoder.sv
// Bench for the PS/2 receiver: directed scenarios plus a randomized byte stream
// compared against a byte-level reference model of prefix collapsing.
module tb_ps2_rx_decoder;
  localparam int FL = 4;
  localparam int TO = 1000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  ps2_rx_decoder_if bus ();

  ps2_rx_decoder #(.FILTER_LEN(FL), .TIMEOUT(TO), .TO_WIDTH(17)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fall_cyc = 0;

  // Observations gathered on the falling clock edge
  logic [7:0] obs_rx[$];
  logic [9:0] obs_key[$];
  int obs_err = 0;
  int err_cyc = 0;
  int viol = 0;
  logic p_rxv = 1'b0, p_err = 1'b0, p_kv = 1'b0;

  // Reference model state
  logic [7:0] exp_rx[$];
  logic [9:0] exp_key[$];
  int exp_err = 0;
  logic m_ext = 1'b0, m_brk = 1'b0;
  logic [7:0] m_rx_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rx_valid) obs_rx.push_back(bus.rx_data);
      if (bus.rx_err) begin
        obs_err = obs_err + 1;
        err_cyc = cyc;
      end
      if (bus.key_valid) obs_key.push_back({bus.key_ext, bus.key_break, bus.key_code});
      if (bus.rx_valid && p_rxv) viol = viol + 1;
      if (bus.rx_err && p_err) viol = viol + 1;
      if (bus.key_valid && p_kv) viol = viol + 1;
      if (bus.rx_valid && bus.rx_err) viol = viol + 1;
    end
    p_rxv = bus.rx_valid;
    p_err = bus.rx_err;
    p_kv  = bus.key_valid;
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_rx.delete();
    obs_key.delete();
    obs_err = 0;
    exp_rx.delete();
    exp_key.delete();
    exp_err = 0;
  endtask

  // Byte-level model: what the receiver should report for one frame
  task automatic model_frame(input logic [7:0] b, input bit bad);
    if (bad) begin
      exp_err = exp_err + 1;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else begin
      exp_rx.push_back(b);
      m_rx_data = b;
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
        exp_key.push_back({m_ext, m_brk, b});
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
    end
  endtask

  // Drive nbits bits of a device-to-host frame; data changes mid-high-phase
  task automatic send_frame(input logic [7:0] b, input bit bad, input int glitch_bit, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      cyc_wait(25);
      ps2_data = bits[i];
      if (i == glitch_bit) begin
        cyc_wait(10);
        ps2_clk = 1'b0;
        cyc_wait(2);
        ps2_clk = 1'b1;
        cyc_wait(13);
      end else begin
        cyc_wait(25);
      end
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      cyc_wait(50);
      ps2_clk = 1'b1;
    end
    if (nbits == 11) begin
      ps2_data = 1'b1;
      model_frame(b, bad);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc_wait(3);
    checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got=%h exp=00", bus.rx_data); end
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got=%b exp=0", bus.rx_valid); end
    checks++; if (bus.rx_err !== 1'b0) begin errors++; $display("FAIL reset_rx_err got=%b exp=0", bus.rx_err); end
    checks++; if ({bus.key_ext, bus.key_break, bus.key_code} !== 10'h000) begin errors++; $display("FAIL reset_key got=%h exp=000", {bus.key_ext, bus.key_break, bus.key_code}); end
    checks++; if (bus.key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid got=%b exp=0", bus.key_valid); end
    reset = 1'b0;
    cyc_wait(10);
  endtask

  task automatic test_make();
    clear_obs();
    send_frame(8'h1C, 1'b0, -1, 11);
    cyc_wait(60);
    checks++; if (obs_rx.size() !== 1) begin errors++; $display("FAIL make_rx_count got=%0d exp=1", obs_rx.size()); end
    checks++; if (bus.rx_data !== 8'h1C) begin errors++; $display("FAIL make_rx_data got=%h exp=1c", bus.rx_data); end
    checks++; if (obs_key.size() !== 1) begin errors++; $display("FAIL make_key_count got=%0d exp=1", obs_key.size()); end
    checks++; if ({bus.key_ext, bus.key_break, bus.key_code} !== {2'b00, 8'h1C}) begin errors++; $display("FAIL make_key got=%h exp=01c", {bus.key_ext, bus.key_break, bus.key_code}); end
    checks++; if (obs_err !== 0) begin errors++; $display("FAIL make_err_count got=%0d exp=0", obs_err); end
  endtask

  task automatic test_prefix();
    clear_obs();
    send_frame(8'hF0, 1'b0, -1, 11);
    send_frame(8'h1C, 1'b0, -1, 11);
    cyc_wait(60);
    checks++; if (obs_rx.size() !== 2) begin errors++; $display("FAIL break_rx_count got=%0d exp=2", obs_rx.size()); end
    checks++; if (obs_key.size() !== 1) begin errors++; $display("FAIL break_key_count got=%0d exp=1", obs_key.size()); end
    checks++; if ({bus.key_ext, bus.key_break, bus.key_code} !== {2'b01, 8'h1C}) begin errors++; $display("FAIL break_key got=%h exp=11c", {bus.key_ext, bus.key_break, bus.key_code}); end
    clear_obs();
    send_frame(8'hE0, 1'b0, -1, 11);
    send_frame(8'hF0, 1'b0, -1, 11);
    send_frame(8'h74, 1'b0, -1, 11);
    cyc_wait(60);
    checks++; if (obs_key.size() !== 1) begin errors++; $display("FAIL ext_break_key_count got=%0d exp=1", obs_key.size()); end
    checks++; if ({bus.key_ext, bus.key_break, bus.key_code} !== {2'b11, 8'h74}) begin errors++; $display("FAIL ext_break_key got=%h exp=374", {bus.key_ext, bus.key_break, bus.key_code}); end
  endtask

  task automatic test_parity();
    clear_obs();
    send_frame(8'h1C, 1'b1, -1, 11);
    cyc_wait(60);
    checks++; if (obs_err !== 1) begin errors++; $display("FAIL parity_err_count got=%0d exp=1", obs_err); end
    checks++; if (obs_rx.size() !== 0) begin errors++; $display("FAIL parity_rx_count got=%0d exp=0", obs_rx.size()); end
    checks++; if (bus.rx_data !== 8'h74) begin errors++; $display("FAIL parity_rx_hold got=%h exp=74", bus.rx_data); end
    clear_obs();
    send_frame(8'hF0, 1'b0, -1, 11);
    send_frame(8'h55, 1'b1, -1, 11);
    send_frame(8'h1C, 1'b0, -1, 11);
    cyc_wait(60);
    checks++; if (obs_key.size() !== 1) begin errors++; $display("FAIL err_clear_key_count got=%0d exp=1", obs_key.size()); end
    checks++; if ({bus.key_ext, bus.key_break, bus.key_code} !== {2'b00, 8'h1C}) begin errors++; $display("FAIL err_clear_key got=%h exp=01c", {bus.key_ext, bus.key_break, bus.key_code}); end
  endtask

  task automatic test_timeout();
    int delta;
    clear_obs();
    send_frame(8'h0F, 1'b0, -1, 6);
    ps2_data = 1'b1;
    cyc_wait(1500 - 50);
    delta = err_cyc - last_fall_cyc;
    checks++; if (obs_err !== 1) begin errors++; $display("FAIL timeout_err_count got=%0d exp=1", obs_err); end
    checks++; if (delta < TO || delta > TO + 15) begin errors++; $display("FAIL timeout_latency got=%0d exp=%0d..%0d", delta, TO, TO + 15); end
    checks++; if (obs_rx.size() !== 0) begin errors++; $display("FAIL timeout_rx_count got=%0d exp=0", obs_rx.size()); end
    m_ext = 1'b0;
    m_brk = 1'b0;
    clear_obs();
    send_frame(8'h2A, 1'b0, -1, 11);
    cyc_wait(60);
    checks++; if (bus.rx_data !== 8'h2A) begin errors++; $display("FAIL timeout_recover_rx got=%h exp=2a", bus.rx_data); end
    checks++; if (obs_err !== 0) begin errors++; $display("FAIL timeout_recover_err got=%0d exp=0", obs_err); end
  endtask

  task automatic test_glitch();
    clear_obs();
    cyc_wait(20);
    ps2_clk = 1'b0;
    cyc_wait(2);
    ps2_clk = 1'b1;
    cyc_wait(60);
    checks++; if (obs_rx.size() + obs_err + obs_key.size() !== 0) begin errors++; $display("FAIL idle_glitch_events got=%0d exp=0", obs_rx.size() + obs_err + obs_key.size()); end
    send_frame(8'h5A, 1'b0, 4, 11);
    cyc_wait(60);
    checks++; if (obs_rx.size() !== 1) begin errors++; $display("FAIL glitch_rx_count got=%0d exp=1", obs_rx.size()); end
    checks++; if (bus.rx_data !== 8'h5A) begin errors++; $display("FAIL glitch_rx_data got=%h exp=5a", bus.rx_data); end
    checks++; if (obs_err !== 0) begin errors++; $display("FAIL glitch_err got=%0d exp=0", obs_err); end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    send_frame(8'h3B, 1'b0, -1, 5);
    ps2_data = 1'b1;
    cyc_wait(10);
    reset = 1'b1;
    cyc_wait(3);
    checks++; if ({bus.rx_data, bus.key_code, bus.key_ext, bus.key_break} !== 18'h0) begin errors++; $display("FAIL midreset_outputs got=%h exp=0", {bus.rx_data, bus.key_code, bus.key_ext, bus.key_break}); end
    reset = 1'b0;
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_rx_data = 8'h00;
    cyc_wait(10);
    send_frame(8'h3B, 1'b0, -1, 11);
    cyc_wait(60);
    checks++; if ({bus.key_ext, bus.key_break, bus.key_code} !== {2'b00, 8'h3B}) begin errors++; $display("FAIL midreset_key got=%h exp=03b", {bus.key_ext, bus.key_break, bus.key_code}); end
    checks++; if (obs_err !== 0) begin errors++; $display("FAIL midreset_err got=%0d exp=0", obs_err); end
    checks++; if (obs_key.size() !== 1) begin errors++; $display("FAIL midreset_key_count got=%0d exp=1", obs_key.size()); end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int r, n;
    bit bad;
    clear_obs();
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2) b = 8'hE0;
      else if (r < 4) b = 8'hF0;
      else if (r == 4) b = 8'hE1;
      else b = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 6) == 0);
      send_frame(b, bad, -1, 11);
    end
    cyc_wait(60);
    checks++; if (obs_rx.size() !== exp_rx.size()) begin errors++; $display("FAIL rand_rx_count got=%0d exp=%0d", obs_rx.size(), exp_rx.size()); end
    checks++; if (obs_key.size() !== exp_key.size()) begin errors++; $display("FAIL rand_key_count got=%0d exp=%0d", obs_key.size(), exp_key.size()); end
    checks++; if (obs_err !== exp_err) begin errors++; $display("FAIL rand_err_count got=%0d exp=%0d", obs_err, exp_err); end
    checks++; if (bus.rx_data !== m_rx_data) begin errors++; $display("FAIL rand_rx_hold got=%h exp=%h", bus.rx_data, m_rx_data); end
    n = (obs_rx.size() < exp_rx.size()) ? obs_rx.size() : exp_rx.size();
    for (int i = 0; i < n; i++) begin
      checks++; if (obs_rx[i] !== exp_rx[i]) begin errors++; $display("FAIL rand_rx[%0d] got=%h exp=%h", i, obs_rx[i], exp_rx[i]); end
    end
    n = (obs_key.size() < exp_key.size()) ? obs_key.size() : exp_key.size();
    for (int i = 0; i < n; i++) begin
      checks++; if (obs_key[i] !== exp_key[i]) begin errors++; $display("FAIL rand_key[%0d] got=%h exp=%h", i, obs_key[i], exp_key[i]); end
    end
  endtask

  task automatic test_pulses();
    checks++; if (viol !== 0) begin errors++; $display("FAIL pulse_rules got=%0d exp=0", viol); end
  endtask

  initial begin
    test_reset();
    test_make();
    test_prefix();
    test_parity();
    test_timeout();
    test_glitch();
    test_reset_mid();
    test_random();
    test_pulses();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ps2_rx_decoder.md
Name: ps2_rx_decoder

Overview:
PS/2 keyboard front end that feeds the key-to-LED path. It synchronises and deglitches the raw ps2_clk/ps2_data pins and deserialises 11-bit device-to-host frames. It checks start, parity and stop bits, then collapses E0/F0 prefix sequences into single key events for the downstream LED/counter logic. A frame watchdog recovers the receiver from truncated frames.

Parameters:
FILTER_LEN, 8, consecutive identical synced ps2_clk samples required before the filtered clock changes level
TIMEOUT, 100000, clk cycles allowed between falling edges inside a frame before abort (1 ms at 100 MHz)
TO_WIDTH, 17, width of watchdog counter; must satisfy 2^TO_WIDTH > TIMEOUT

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
ps2_clk  input  1  raw PS/2 clock pin, asynchronous, idle high
ps2_data  input  1  raw PS/2 data pin, asynchronous, idle high
rx_data  output  8  last correctly received byte, held until next good frame
rx_valid  output  1  one-cycle pulse: rx_data updated
rx_err  output  1  one-cycle pulse: frame rejected (start/parity/stop/timeout)
key_code  output  8  scan code of last key event, held
key_break  output  1  key event is a release (F0 prefix seen), held with key_code
key_ext  output  1  key event is extended (E0 prefix seen), held with key_code
key_valid  output  1  one-cycle pulse: key_code/key_break/key_ext updated

Behaviour:
- Reset is asynchronous and active-high; clk is the only clock. Reset values: 2-FF synchroniser stages = 1; filtered clock = 1; filter count = 0; FSM = IDLE; bit count, shift register, watchdog = 0; all outputs = 0; E0/F0 pending flags = 0.
- Synchronise both pins through 2 flops. Filter: if synced clk equals filtered clk, clear filter count. Otherwise increment it; on reaching FILTER_LEN-1, flip filtered clk and clear the count.
- fall tick = filtered clk 1->0. Data is sampled from synced ps2_data in the tick cycle.
- Pin-to-tick latency: 2 + FILTER_LEN clk. A pulse shorter than FILTER_LEN cycles is ignored.
- FSM, advancing only on a fall tick:
  - IDLE: data=0 -> DATA with bit count cleared. Data=1 -> stay in IDLE, no error.
  - DATA: shift in LSB first, bit 0 first. After the 8th bit -> PARITY.
  - PARITY: capture bit -> STOP.
  - STOP: good frame requires data=1 and odd parity over the 8 data bits plus the parity bit. Good -> rx_data loaded and rx_valid pulse in the following cycle. Bad -> rx_err pulse in the following cycle, rx_data unchanged. Always -> IDLE.
- Watchdog: cleared on every fall tick and while in IDLE, otherwise increments. Reaching TIMEOUT-1 outside IDLE -> IDLE, partial frame discarded, rx_err pulse. A timeout and a fall tick in the same cycle: the tick wins.
- Decoder acts on rx_valid:
  - byte E0 -> set ext pending.
  - byte F0 -> set break pending.
  - any other byte (including E1) -> key_code=byte, key_break=break pending, key_ext=ext pending, key_valid pulse one cycle after rx_valid, both pending flags cleared.
  - F0/E0 alone never produce key_valid.
- rx_err clears both pending flags. A repeated prefix (E0 E0) is idempotent.
- rx_valid, rx_err and key_valid are never asserted for more than one cycle. rx_valid and rx_err are mutually exclusive.
- Reset mid-frame: all state is returned to reset values immediately. The next frame is received normally if its start bit arrives after reset deasserts.
- Host-to-device transmission is out of scope; the pins are input-only.

Test Plan:
Bench settings: FILTER_LEN=4, TIMEOUT=1000, PS/2 half-period = 50 clk, data changed mid-high-phase.
1. Frame 0x1C, correct parity -> rx_valid once, rx_data=0x1C; key_valid once, key_code=0x1C, key_break=0, key_ext=0; rx_err never asserted.
2. Frames F0,1C -> two rx_valid pulses; exactly one key_valid, key_code=0x1C, key_break=1, key_ext=0. Then E0,F0,74 -> one key_valid, key_code=0x74, key_break=1, key_ext=1.
3. Frame 0x1C with parity bit inverted -> rx_err pulse, no rx_valid, rx_data keeps its previous value. Send F0 then a bad frame then 1C -> key_break=0 on the 1C event.
4. Start bit plus 5 data bits, then clock held high for 1500 clk -> rx_err pulse after 1000 clk. A following good frame 0x2A -> rx_data=0x2A.
5. 2-clk low glitch on ps2_clk while idle and mid-frame -> no state change; frame 0x5A still received correctly.
6. Reset asserted after the 4th data bit of 0x3B, then released -> outputs 0, FSM IDLE. A following frame 0x3B yields key_code=0x3B with no rx_err.
